pow_5_pipe_arbiter: RTL and testbench

//  Shares one pipelined pow_5 unit (fixed latency, clock-enabled) among N requesters.

---
 rtl/pow_5_pipe_arbiter_pkg.sv | 21 ++
 rtl/pow_5_arb_tag_pipe.sv | 40 ++++
 rtl/pow_5_pipe_arbiter.sv | 151 +++++++++++++++
 tb/tb_pow_5_pipe_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pow_5_pipe_arbiter_pkg.sv
// Shared types and helpers for the pow_5 pipeline arbiter: requester tag layout,
// counter width and a saturating increment.
package pow_5_pipe_arbiter_pkg;

    // Tag id is sized for the largest supported requester count (N up to 8).
    localparam int N_MAX = 8;
    localparam int ID_W  = $clog2(N_MAX);
    localparam int CNT_W = 16;

    typedef struct packed {
        logic            vld;
        logic [ID_W-1:0] id;
    } arb_tag_t;

    localparam arb_tag_t TAG_NONE = '{vld: 1'b0, id: '0};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/pow_5_arb_tag_pipe.sv
// LAT-deep shift register of requester tags, advancing only on enabled cycles so it
// stays aligned with the clock-enabled pow_5 datapath; head_o is the oldest tag.
module pow_5_arb_tag_pipe
    import pow_5_pipe_arbiter_pkg::*;
#(
    parameter int LAT = 4
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     en_i,
    input  arb_tag_t tag_i,
    output arb_tag_t head_o
);

    arb_tag_t stage_q [LAT];
    arb_tag_t stage_d [LAT];

    always_comb begin
        stage_d = stage_q;
        if (en_i) begin
            stage_d[0] = tag_i;
            for (int s = 1; s < LAT; s++) begin
                stage_d[s] = stage_q[s-1];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int s = 0; s < LAT; s++) begin
                stage_q[s] <= TAG_NONE;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign head_o = stage_q[LAT-1];

endmodule

// File: rtl/pow_5_pipe_arbiter.sv
// Round-robin arbiter sharing one clock-enabled pow_5 pipeline among N requesters;
// results are routed back by tag. Define POW5_ARB_STATS_EN for per-requester grant counters.
module pow_5_pipe_arbiter
    import pow_5_pipe_arbiter_pkg::*;
#(
    parameter int N   = 4,
    parameter int W   = 8,
    parameter int RW  = 32,
    parameter int LAT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clk_en,
    input  logic [N-1:0]    req_vld,
    input  logic [N*W-1:0]  req_n,
    output logic [N-1:0]    req_rdy,
    output logic            pipe_n_vld,
    output logic [W-1:0]    pipe_n,
    input  logic            pipe_res_vld,
    input  logic [RW-1:0]   pipe_res,
    output logic [N-1:0]    out_vld,
    output logic [N*RW-1:0] out_res,
    output logic            err
`ifdef POW5_ARB_STATS_EN
    ,
    output logic [N*CNT_W-1:0] grant_cnt
`endif
);

    // Handshake: requester i transfers its operand on a rising edge where
    // req_vld[i] & req_rdy[i]; req_rdy is a combinational one-hot grant that is
    // only ever raised on enabled cycles, and requesters hold req_n stable until then.

    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [ID_W-1:0] win;
    logic            found;
    logic            issue;
    arb_tag_t        tag_in;
    arb_tag_t        head;

    logic [N-1:0]    out_vld_q, out_vld_d;
    logic [N*RW-1:0] out_res_q, out_res_d;
    logic            err_q, err_d;

    // First valid requester at or after ptr, wrapping mod N; MSB of result = found.
    function automatic logic [ID_W:0] rr_pick(input logic [N-1:0] vld,
                                              input logic [ID_W-1:0] ptr);
        logic [N_MAX-1:0] v;
        logic [ID_W:0]    r;
        int               s;
        v = '0;
        v[N-1:0] = vld;
        r = '0;
        for (int k = 0; k < N; k++) begin
            s = int'(ptr) + k;
            if (s >= N) s = s - N;
            if (!r[ID_W] && v[ID_W'(s)]) r = {1'b1, ID_W'(s)};
        end
        return r;
    endfunction

    always_comb begin
        {found, win} = rr_pick(req_vld, ptr_q);
        issue        = clk_en && found;
        req_rdy      = issue ? (N'(1) << win) : '0;
        pipe_n_vld   = issue;
        pipe_n       = issue ? req_n[win*W +: W] : '0;
        tag_in       = issue ? '{vld: 1'b1, id: win} : TAG_NONE;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (issue) begin
            ptr_d = (win == ID_W'(N-1)) ? '0 : win + 1'b1;
        end
    end

    pow_5_arb_tag_pipe #(
        .LAT (LAT)
    ) u_tag_pipe (
        .clk_i  (clk),
        .rst_i  (rst),
        .en_i   (clk_en),
        .tag_i  (tag_in),
        .head_o (head)
    );

    // A result is accepted only when it lines up with a valid head tag; any
    // disagreement drops the result and latches err until reset.
    always_comb begin
        out_vld_d = '0;
        out_res_d = out_res_q;
        err_d     = err_q;
        if (clk_en) begin
            if (pipe_res_vld != head.vld) begin
                err_d = 1'b1;
            end else if (pipe_res_vld) begin
                for (int i = 0; i < N; i++) begin
                    if (head.id == ID_W'(i)) begin
                        out_vld_d[i]             = 1'b1;
                        out_res_d[i*RW +: RW]    = pipe_res;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q     <= '0;
            out_vld_q <= '0;
            out_res_q <= '0;
            err_q     <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            out_vld_q <= out_vld_d;
            out_res_q <= out_res_d;
            err_q     <= err_d;
        end
    end

    assign out_vld = out_vld_q;
    assign out_res = out_res_q;
    assign err     = err_q;

`ifdef POW5_ARB_STATS_EN
    logic [CNT_W-1:0] cnt_q [N];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (req_vld[i] && req_rdy[i]) begin
                    cnt_q[i] <= sat_inc(cnt_q[i]);
                end
            end
        end
    end

    always_comb begin
        grant_cnt = '0;
        for (int i = 0; i < N; i++) begin
            grant_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_pow_5_pipe_arbiter.sv
// Directed bench for pow_5_pipe_arbiter with a behavioural clock-enabled pow_5 pipeline
// attached; build with +define+POW5_ARB_STATS_EN to cover the grant counters.
module tb_pow_5_pipe_arbiter;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int RW  = 32;
    localparam int LAT = 4;

    typedef struct {
        int            id;
        logic [RW-1:0] res;
        int            cyc;
    } mon_rec_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            clk_en = 1'b0;
    logic [N-1:0]    req_vld = '0;
    logic [N*W-1:0]  req_n = '0;
    logic [N-1:0]    req_rdy;
    logic            pipe_n_vld;
    logic [W-1:0]    pipe_n;
    logic            pipe_res_vld;
    logic [RW-1:0]   pipe_res;
    logic [N-1:0]    out_vld;
    logic [N*RW-1:0] out_res;
    logic            err;
`ifdef POW5_ARB_STATS_EN
    logic [N*16-1:0] grant_cnt;
`endif

    logic            force_vld = 1'b0;
    logic            mdl_vld [LAT];
    logic [RW-1:0]   mdl_res [LAT];
    int              cyc = 0;
    int              n_vec = 0;
    int              n_fail = 0;
    mon_rec_t        mon_q [$];
    logic [RW-1:0]   exp_q [$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pow_5_pipe_arbiter #(.N(N), .W(W), .RW(RW), .LAT(LAT)) dut (
        .clk          (clk),
        .rst          (rst),
        .clk_en       (clk_en),
        .req_vld      (req_vld),
        .req_n        (req_n),
        .req_rdy      (req_rdy),
        .pipe_n_vld   (pipe_n_vld),
        .pipe_n       (pipe_n),
        .pipe_res_vld (pipe_res_vld),
        .pipe_res     (pipe_res),
        .out_vld      (out_vld),
        .out_res      (out_res),
        .err          (err)
`ifdef POW5_ARB_STATS_EN
        ,
        .grant_cnt    (grant_cnt)
`endif
    );

    function automatic logic [RW-1:0] pow5(input logic [W-1:0] n);
        logic [RW-1:0] x;
        x = RW'(n);
        return x * x * x * x * x;
    endfunction

    // Behavioural pow_5 datapath sharing clk, rst and clk_en with the arbiter.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < LAT; s++) begin
                mdl_vld[s] <= 1'b0;
                mdl_res[s] <= '0;
            end
        end else if (clk_en) begin
            mdl_vld[0] <= pipe_n_vld;
            mdl_res[0] <= pow5(pipe_n);
            for (int s = 1; s < LAT; s++) begin
                mdl_vld[s] <= mdl_vld[s-1];
                mdl_res[s] <= mdl_res[s-1];
            end
        end
    end

    assign pipe_res_vld = mdl_vld[LAT-1] | force_vld;
    assign pipe_res     = mdl_res[LAT-1];

    // Records every result pulse, one entry per set out_vld bit per cycle.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                if (out_vld[i]) mon_q.push_back('{id: i, res: out_res[i*RW +: RW], cyc: cyc});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached, got no finish want finish");
        $fatal(1, "timeout");
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; clk_en = 1'b0; req_vld = '0; req_n = '0; force_vld = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mon_q.delete();
    endtask

    task automatic test_reset();
        #1;
        n_vec++; if (out_vld !== 4'b0000) begin n_fail++; $display("FAIL reset_out_vld: got %b want 0000", out_vld); end
        n_vec++; if (out_res !== '0) begin n_fail++; $display("FAIL reset_out_res: got %h want 0", out_res); end
        n_vec++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
        n_vec++; if (req_rdy !== 4'b0000) begin n_fail++; $display("FAIL reset_rdy: got %b want 0000", req_rdy); end
        clk_en = 1'b0; req_vld = 4'b1111;
        #1;
        n_vec++; if (req_rdy !== 4'b0000) begin n_fail++; $display("FAIL rdy_no_en: got %b want 0000", req_rdy); end
        req_vld = '0;
    endtask

    task automatic test_single_req();
        int c0 = 0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            clk_en = 1'b1; req_vld = 4'b0001; req_n[0 +: W] = 8'd3;
            #1;
            if (i == 0) c0 = cyc + 1;
            n_vec++; if (req_rdy !== 4'b0001) begin n_fail++; $display("FAIL single_rdy[%0d]: got %b want 0001", i, req_rdy); end
            n_vec++; if (pipe_n !== 8'd3) begin n_fail++; $display("FAIL single_pipe_n[%0d]: got %0d want 3", i, pipe_n); end
        end
        @(negedge clk); req_vld = '0;
        #1;
        n_vec++; if (pipe_n_vld !== 1'b0 || pipe_n !== 8'd0) begin n_fail++; $display("FAIL idle_pipe: got vld=%b n=%0d want vld=0 n=0", pipe_n_vld, pipe_n); end
        repeat (LAT + 4) @(negedge clk);
        n_vec++; if (mon_q.size() != 3) begin n_fail++; $display("FAIL single_count: got %0d pulses want 3", mon_q.size()); end
        for (int i = 0; i < 3 && i < mon_q.size(); i++) begin
            n_vec++;
            if (mon_q[i].id != 0 || mon_q[i].res !== 32'd243 || mon_q[i].cyc != c0 + LAT + i) begin
                n_fail++;
                $display("FAIL single_result[%0d]: got id=%0d res=%0d cyc=%0d want id=0 res=243 cyc=%0d",
                         i, mon_q[i].id, mon_q[i].res, mon_q[i].cyc, c0 + LAT + i);
            end
        end
        n_vec++; if (out_res[0 +: RW] !== 32'd243) begin n_fail++; $display("FAIL single_hold: got %0d want 243", out_res[0 +: RW]); end
    endtask

    task automatic test_all_four();
        logic [N-1:0] pend = 4'b1111;
        logic [N-1:0] exp_rdy;
        do_reset();
        exp_q.delete();
        exp_q.push_back(32'd1); exp_q.push_back(32'd32); exp_q.push_back(32'd243); exp_q.push_back(32'd1024);
        req_n = {8'd4, 8'd3, 8'd2, 8'd1};
        for (int g = 0; g < N; g++) begin
            @(negedge clk);
            clk_en = 1'b1; req_vld = pend;
            #1;
            exp_rdy = 4'b0001 << g;
            n_vec++; if (req_rdy !== exp_rdy) begin n_fail++; $display("FAIL rr_grant[%0d]: got %b want %b", g, req_rdy, exp_rdy); end
            pend = pend & ~(req_vld & req_rdy);
        end
        @(negedge clk); req_vld = '0;
        repeat (LAT + 4) @(negedge clk);
        n_vec++; if (mon_q.size() != 4) begin n_fail++; $display("FAIL rr_count: got %0d pulses want 4", mon_q.size()); end
        for (int i = 0; i < 4 && i < mon_q.size(); i++) begin
            n_vec++;
            if (mon_q[i].id != i || mon_q[i].res !== exp_q[i]) begin
                n_fail++;
                $display("FAIL rr_result[%0d]: got id=%0d res=%0d want id=%0d res=%0d", i, mon_q[i].id, mon_q[i].res, i, exp_q[i]);
            end
        end
        n_vec++; if (err !== 1'b0) begin n_fail++; $display("FAIL rr_err: got %b want 0", err); end
    endtask

    task automatic test_clk_en_gaps();
        logic pend = 1'b1;
        logic [N-1:0] exp_rdy;
        do_reset();
        req_n[2*W +: W] = 8'd2;
        for (int k = 0; k < 36; k++) begin
            @(negedge clk);
            clk_en = (k % 3 == 0);
            req_vld = pend ? 4'b0100 : 4'b0000;
            #1;
            exp_rdy = (clk_en && pend) ? 4'b0100 : 4'b0000;
            n_vec++; if (req_rdy !== exp_rdy) begin n_fail++; $display("FAIL gap_rdy[%0d]: got %b want %b", k, req_rdy, exp_rdy); end
            if (req_vld[2] && req_rdy[2]) pend = 1'b0;
        end
        @(negedge clk); clk_en = 1'b0;
        n_vec++; if (mon_q.size() != 1) begin n_fail++; $display("FAIL gap_count: got %0d pulses want 1", mon_q.size()); end
        if (mon_q.size() > 0) begin
            n_vec++;
            if (mon_q[0].id != 2 || mon_q[0].res !== 32'd32) begin
                n_fail++; $display("FAIL gap_result: got id=%0d res=%0d want id=2 res=32", mon_q[0].id, mon_q[0].res);
            end
        end
        n_vec++; if (out_res[2*RW +: RW] !== 32'd32) begin n_fail++; $display("FAIL gap_hold: got %0d want 32", out_res[2*RW +: RW]); end
    endtask

    task automatic test_err_sticky();
        do_reset();
        @(negedge clk); clk_en = 1'b0; force_vld = 1'b1;
        @(negedge clk); force_vld = 1'b0;
        n_vec++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_disabled: got %b want 0", err); end
        clk_en = 1'b1; force_vld = 1'b1;
        @(negedge clk); force_vld = 1'b0;
        n_vec++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b want 1", err); end
        n_vec++; if (out_vld !== 4'b0000) begin n_fail++; $display("FAIL err_out_vld: got %b want 0000", out_vld); end
        repeat (5) @(negedge clk);
        n_vec++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b want 1", err); end
        n_vec++; if (mon_q.size() != 0) begin n_fail++; $display("FAIL err_no_pulse: got %0d pulses want 0", mon_q.size()); end
        do_reset();
        #1;
        n_vec++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_cleared: got %b want 0", err); end
    endtask

    task automatic test_reset_inflight();
        logic [N-1:0] pend = 4'b0111;
        do_reset();
        req_n = {8'd2, 8'd7, 8'd6, 8'd5};
        for (int g = 0; g < 3; g++) begin
            @(negedge clk);
            clk_en = 1'b1; req_vld = pend;
            #1;
            pend = pend & ~(req_vld & req_rdy);
        end
        @(negedge clk); req_vld = '0;
        #2 rst = 1'b1;
        #1;
        n_vec++; if (out_vld !== 4'b0000 || err !== 1'b0) begin n_fail++; $display("FAIL rst_async_out: got vld=%b err=%b want vld=0000 err=0", out_vld, err); end
        req_vld = 4'b1111;
        #1;
        n_vec++; if (req_rdy !== 4'b0001) begin n_fail++; $display("FAIL rst_ptr: got %b want 0001", req_rdy); end
        @(negedge clk);
        req_vld = 4'b1000;
        rst = 1'b0;
        mon_q.delete();
        #1;
        n_vec++; if (req_rdy !== 4'b1000) begin n_fail++; $display("FAIL rst_first_grant: got %b want 1000", req_rdy); end
        @(negedge clk); req_vld = '0;
        repeat (LAT + 4) @(negedge clk);
        n_vec++; if (mon_q.size() != 1) begin n_fail++; $display("FAIL rst_count: got %0d pulses want 1", mon_q.size()); end
        if (mon_q.size() > 0) begin
            n_vec++;
            if (mon_q[0].id != 3 || mon_q[0].res !== 32'd32) begin
                n_fail++; $display("FAIL rst_result: got id=%0d res=%0d want id=3 res=32", mon_q[0].id, mon_q[0].res);
            end
        end
        n_vec++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", err); end
    endtask

`ifdef POW5_ARB_STATS_EN
    task automatic test_stats();
        logic [15:0] exp_cnt [N];
        exp_cnt[0] = 16'd0; exp_cnt[1] = 16'd10; exp_cnt[2] = 16'd0; exp_cnt[3] = 16'd5;
        do_reset();
        clk_en = 1'b1;
        req_n = {8'd1, 8'd1, 8'd1, 8'd1};
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            req_vld = (k < 10) ? 4'b0010 : 4'b1000;
        end
        @(negedge clk); req_vld = '0;
        repeat (LAT + 3) @(negedge clk);
        for (int i = 0; i < N; i++) begin
            n_vec++;
            if (grant_cnt[i*16 +: 16] !== exp_cnt[i]) begin
                n_fail++; $display("FAIL stats_cnt[%0d]: got %0d want %0d", i, grant_cnt[i*16 +: 16], exp_cnt[i]);
            end
        end
        n_vec++; if (mon_q.size() != 15) begin n_fail++; $display("FAIL stats_results: got %0d pulses want 15", mon_q.size()); end
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single_req();
        test_all_four();
        test_clk_en_gaps();
        test_err_sticky();
        test_reset_inflight();
`ifdef POW5_ARB_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
